sssp_ro_resp_unroller: RTL and testbench
========================================

Name: sssp_ro_resp_unroller

Overview:
- Sits between the SSSP RO stage's memory-read port and the per-subtype subtask FIFOs.
- Accepts each RO read request (address, burst length, response task, response subtype, last-mark and CQ slot) and tags it.
- Issues the request to the tile's AXI read channel.
- Unrolls every returned beat into one subtask carrying the task, the 64-bit data word and the word index. These subtasks feed RO subtypes 1 and 2 (offset pair, then neighbour/weight pairs).

Parameters:
N_TAGS, 8, outstanding read contexts; power of two, 2..16
TILE_ID, 0, tile index used only in simulation display

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
req_valid  in  1  RO read request valid
req_ready  out  1  request accepted this cycle
req_araddr  in  32  byte address
req_arlen  in  8  beats minus one
req_arsize  in  3  beat size (3 = 8 bytes)
req_task  in  task_t  task template for every response subtask
req_subtype  in  subtype_t  subtype given to response subtasks
req_mark_last  in  1  flag the final beat's subtask as last
req_cq_slot  in  cq_slice_slot_t  CQ slot of the parent task
m_arvalid / m_arready  out / in  1 / 1  AXI AR handshake
m_araddr, m_arlen, m_arsize  out  32, 8, 3  AXI AR fields
m_arid  out  log2(N_TAGS)  context tag
m_rvalid / m_rready  in / out  1 / 1  AXI R handshake
m_rid  in  log2(N_TAGS)  response tag
m_rdata  in  64  beat data
m_rlast  in  1  final beat of burst
out_valid / out_ready  out / in  1 / 1  subtask handshake
out_task  out  task_t  copied from context
out_data  out  data_t  m_rdata of the beat
out_word_id  out  byte_t  beat index within burst, from 0
out_subtype  out  subtype_t  from context
out_cq_slot  out  cq_slice_slot_t  from context
out_last  out  1  context mark_last AND m_rlast
err_unalloc  out  1  sticky: beat arrived for a free tag
outstanding  out  log2(N_TAGS)+1  contexts currently allocated

Behaviour:
- Reset (async assert, sync deassert into the logic): m_arvalid=0, out_valid=0, m_rready=0 until first cycle after reset, free mask all ones, beat counters 0, err_unalloc=0, outstanding=0. Reset mid-burst discards all contexts; no beats are emitted afterwards for pre-reset tags.
- Allocation:
  - req_ready = (free mask != 0) & (!m_arvalid | m_arready).
  - On req_valid & req_ready, take the lowest free tag, clear its free bit and write its context (task, subtype, mark_last, cq_slot, beat counter = 0).
  - Load the registered AR stage next cycle: AR latency 1.
- AR stage: m_arvalid held with stable fields until m_arready. Back-to-back requests are supported: at most one per cycle with m_arready=1.
- Response path:
  - Single output register. m_rready = !out_valid | out_ready.
  - On a beat accepted (m_rvalid & m_rready) for an allocated tag:
    - Next cycle out_valid=1 with the context fields, out_data=m_rdata and out_word_id = beat counter.
    - The beat counter increments (8-bit; wrap at 256 is unreachable since arlen ≤ 255).
  - Output fields stay stable while out_valid & !out_ready.
- Free: on an accepted beat with m_rlast=1, the tag's free bit is set at that clock edge. The tag is allocatable in the following cycle, never in the same cycle.
- Interleaving: beats of different tags may interleave. Each tag keeps its own counter, so word_id is per-tag correct.
- Unallocated rid: the beat is consumed (m_rready applies), no subtask is produced, err_unalloc is set and stays set until reset.
- outstanding = popcount(~free mask). It updates the same cycle as allocate/free; a simultaneous allocate and free leaves it unchanged.
- Full (no free tag): req_ready=0, and the response path keeps draining.
- XILINX_SIMULATOR: $display on each accepted output carrying cycle, TILE_ID, cq_slot, ts, locale, word_id and data.

Test Plan:
- Request arlen=0, subtype=1, locale=5, ts=10. Memory returns rid=0, data=0x0000000C_00000008, rlast=1 → one subtask: word_id=0, data 0x0000000C_00000008, subtype 1, out_last=mark_last. Tag 0 is freed and outstanding returns to 0.
- Request arlen=3, mark_last=1, 4 beats with out_ready=1 → word_ids 0,1,2,3 on consecutive cycles; out_last=1 only on word 3.
- 8 requests with no responses → 9th request sees req_ready=0. Return rlast for tag 2 → req_ready=1 the next cycle, and the new request receives m_arid=2.
- Interleave beats of tags 0 and 1 (arlen=1 each: 0,1,0,1) → word_ids 0,0,1,1 with the correct per-tag task/subtype on each.
- Hold out_ready=0 for 5 cycles mid-burst → m_rready=0 after the first beat, out_* stable, and no beat is lost or duplicated.
- Beat with rid=6 while tag 6 is free → no out_valid, err_unalloc=1. Asserting rstn=0 mid-burst → all outputs 0 immediately and outstanding=0.

Source files
------------

// File: rtl/sssp_ro_resp_unroller.sv
// rtl/sssp_ro_resp_unroller.sv - tags RO read requests, issues AXI AR, unrolls R beats into subtasks
package sssp_ro_pkg;
    typedef struct packed {
        logic [31:0] ts;
        logic [15:0] locale;
        logic [15:0] args;
    } task_t;
    typedef logic [2:0]  subtype_t;
    typedef logic [7:0]  cq_slice_slot_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  byte_t;
endpackage

module sssp_ro_resp_unroller
    import sssp_ro_pkg::*;
#(
    parameter int N_TAGS  = 8,
    parameter int TILE_ID = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 req_araddr,
    input  logic [7:0]                  req_arlen,
    input  logic [2:0]                  req_arsize,
    input  task_t                       req_task,
    input  subtype_t                    req_subtype,
    input  logic                        req_mark_last,
    input  cq_slice_slot_t              req_cq_slot,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [31:0]                 m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [$clog2(N_TAGS)-1:0]   m_arid,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [$clog2(N_TAGS)-1:0]   m_rid,
    input  logic [63:0]                 m_rdata,
    input  logic                        m_rlast,
    output logic                        out_valid,
    input  logic                        out_ready,
    output task_t                       out_task,
    output data_t                       out_data,
    output byte_t                       out_word_id,
    output subtype_t                    out_subtype,
    output cq_slice_slot_t              out_cq_slot,
    output logic                        out_last,
    output logic                        err_unalloc,
    output logic [$clog2(N_TAGS):0]     outstanding
);
    localparam int TW = $clog2(N_TAGS);

    // Out-of-range configurations elaborate this empty marker scope for easy spotting.
    if (N_TAGS < 2 || N_TAGS > 16 || (N_TAGS & (N_TAGS - 1)) != 0 || TILE_ID < 0) begin : g_bad_param
    end

    logic                   active;
    logic [N_TAGS-1:0]      free_mask;
    task_t                  ctx_task    [N_TAGS];
    subtype_t               ctx_subtype [N_TAGS];
    logic                   ctx_last    [N_TAGS];
    cq_slice_slot_t         ctx_cq      [N_TAGS];
    byte_t                  beat_cnt    [N_TAGS];
    logic [TW-1:0]          alloc_tag;
    logic                   alloc_fire;
    logic                   beat_fire;
    logic                   beat_hit;

    always_comb begin
        alloc_tag = '0;
        for (int i = N_TAGS - 1; i >= 0; i--) begin
            if (free_mask[i]) alloc_tag = TW'(i);
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N_TAGS; i++) begin
            outstanding = outstanding + {{TW{1'b0}}, ~free_mask[i]};
        end
    end

    // active gates both ready signals so nothing is taken during or on the edge leaving reset
    assign req_ready  = active & (|free_mask) & (!m_arvalid | m_arready);
    assign m_rready   = active & (!out_valid | out_ready);
    assign alloc_fire = req_valid & req_ready;
    assign beat_fire  = m_rvalid & m_rready;
    assign beat_hit   = beat_fire & !free_mask[m_rid];

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ctx_task[alloc_tag]    <= req_task;
            ctx_subtype[alloc_tag] <= req_subtype;
            ctx_last[alloc_tag]    <= req_mark_last;
            ctx_cq[alloc_tag]      <= req_cq_slot;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active      <= 1'b0;
            free_mask   <= '1;
            err_unalloc <= 1'b0;
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            m_arlen     <= '0;
            m_arsize    <= '0;
            m_arid      <= '0;
            out_valid   <= 1'b0;
            out_task    <= '0;
            out_data    <= '0;
            out_word_id <= '0;
            out_subtype <= '0;
            out_cq_slot <= '0;
            out_last    <= 1'b0;
            for (int i = 0; i < N_TAGS; i++) beat_cnt[i] <= '0;
        end else begin
            active <= 1'b1;
            if (alloc_fire) begin
                free_mask[alloc_tag] <= 1'b0;
                beat_cnt[alloc_tag]  <= '0;
                m_arvalid            <= 1'b1;
                m_araddr             <= req_araddr;
                m_arlen              <= req_arlen;
                m_arsize             <= req_arsize;
                m_arid               <= alloc_tag;
            end else if (m_arready) begin
                m_arvalid <= 1'b0;
            end
            // A freed tag can never be the one allocated in the same cycle.
            if (beat_hit) begin
                beat_cnt[m_rid] <= beat_cnt[m_rid] + 8'd1;
                if (m_rlast) free_mask[m_rid] <= 1'b1;
            end
            if (beat_fire && free_mask[m_rid]) err_unalloc <= 1'b1;
            if (beat_hit) begin
                out_valid   <= 1'b1;
                out_task    <= ctx_task[m_rid];
                out_data    <= m_rdata;
                out_word_id <= beat_cnt[m_rid];
                out_subtype <= ctx_subtype[m_rid];
                out_cq_slot <= ctx_cq[m_rid];
                out_last    <= ctx_last[m_rid] & m_rlast;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef XILINX_SIMULATOR
    logic [31:0] sim_cycle;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sim_cycle <= '0;
        else       sim_cycle <= sim_cycle + 32'd1;
    end
    always_ff @(posedge clk) begin
        if (out_valid && out_ready)
            $display("[%0d] tile %0d ro_resp cq=%0d ts=%0d locale=%0d word=%0d data=%h",
                     sim_cycle, TILE_ID, out_cq_slot, out_task.ts, out_task.locale, out_word_id, out_data);
    end
`endif
endmodule

// File: tb/tb_sssp_ro_resp_unroller.sv
// tb/tb_sssp_ro_resp_unroller.sv - randomized + directed bench for sssp_ro_resp_unroller
module tb_sssp_ro_resp_unroller;
    import sssp_ro_pkg::*;
    localparam int N_TAGS = 8;
    localparam int TW     = 3;

    logic clk, rstn;
    logic req_valid, req_ready;
    logic [31:0] req_araddr;
    logic [7:0] req_arlen;
    logic [2:0] req_arsize;
    task_t req_task;
    subtype_t req_subtype;
    logic req_mark_last;
    cq_slice_slot_t req_cq_slot;
    logic m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [7:0] m_arlen;
    logic [2:0] m_arsize;
    logic [TW-1:0] m_arid;
    logic m_rvalid, m_rready;
    logic [TW-1:0] m_rid;
    logic [63:0] m_rdata;
    logic m_rlast;
    logic out_valid, out_ready;
    task_t out_task;
    data_t out_data;
    byte_t out_word_id;
    subtype_t out_subtype;
    cq_slice_slot_t out_cq_slot;
    logic out_last, err_unalloc;
    logic [TW:0] outstanding;

    sssp_ro_resp_unroller #(.N_TAGS(N_TAGS), .TILE_ID(0)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arsize(req_arsize), .req_task(req_task), .req_subtype(req_subtype),
        .req_mark_last(req_mark_last), .req_cq_slot(req_cq_slot),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task), .out_data(out_data),
        .out_word_id(out_word_id), .out_subtype(out_subtype), .out_cq_slot(out_cq_slot),
        .out_last(out_last), .err_unalloc(err_unalloc), .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { task_t tk; subtype_t st; logic mark; cq_slice_slot_t cq; } ctx_t;
    typedef struct { task_t tk; data_t d; int w; subtype_t st; cq_slice_slot_t cq; logic last; } sub_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; int id; } ar_t;

    ctx_t m_ctx[N_TAGS];
    int   m_word[N_TAGS];
    bit   m_busy[N_TAGS];
    sub_t exp_q[$];
    ar_t  ar_q[$];
    bit   exp_err, mdl_active;
    bit   mem_on[N_TAGS];
    int   mem_len[N_TAGS];
    int   mem_idx[N_TAGS];
    bit   r_pend, req_pend, prev_stall;
    sub_t snap;

    function automatic int n_busy();
        int n = 0;
        for (int i = 0; i < N_TAGS; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < N_TAGS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_TAGS; i++) begin
            m_busy[i] = 0; mem_on[i] = 0; m_word[i] = 0; mem_idx[i] = 0; mem_len[i] = 0;
        end
        exp_q.delete(); ar_q.delete();
        exp_err = 0; mdl_active = 0; r_pend = 0; req_pend = 0; prev_stall = 0;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        int t;
        bit rr_exp;
        sub_t e;
        ar_t a;
        #1;
        t = lowest_free();
        rr_exp = mdl_active && (t >= 0) && (ar_q.size() == 0 || m_arready);
        chk("req_ready", req_ready, rr_exp);
        chk("m_rready", m_rready, mdl_active && (exp_q.size() == 0 || out_ready));
        chk("outstanding", outstanding, n_busy());
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("m_arvalid", m_arvalid, ar_q.size() != 0);
        chk("err_unalloc", err_unalloc, exp_err);
        if (prev_stall) begin
            chk("stable_data", out_data, snap.d);
            chk("stable_word", out_word_id, snap.w);
            chk("stable_task", out_task, snap.tk);
            chk("stable_last", out_last, snap.last);
        end
        if (m_arvalid && m_arready && ar_q.size() != 0) begin
            a = ar_q.pop_front();
            chk("araddr", m_araddr, a.addr);
            chk("arlen", m_arlen, a.len);
            chk("arsize", m_arsize, a.size);
            chk("arid", m_arid, a.id);
            mem_on[a.id] = 1; mem_len[a.id] = a.len; mem_idx[a.id] = 0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("out_task", out_task, e.tk);
                chk("out_data", out_data, e.d);
                chk("out_word_id", out_word_id, e.w);
                chk("out_subtype", out_subtype, e.st);
                chk("out_cq_slot", out_cq_slot, e.cq);
                chk("out_last", out_last, e.last);
            end
        end
        if (req_valid && req_ready) begin
            m_busy[t] = 1; m_word[t] = 0;
            m_ctx[t] = '{tk: req_task, st: req_subtype, mark: req_mark_last, cq: req_cq_slot};
            ar_q.push_back('{addr: req_araddr, len: req_arlen, size: req_arsize, id: t});
            req_pend = 0;
        end else req_pend = req_valid;
        if (m_rvalid && m_rready) begin
            t = int'(m_rid);
            if (m_busy[t]) begin
                exp_q.push_back('{tk: m_ctx[t].tk, d: m_rdata, w: m_word[t], st: m_ctx[t].st,
                                  cq: m_ctx[t].cq, last: m_ctx[t].mark && m_rlast});
                m_word[t]++;
                if (m_rlast) m_busy[t] = 0;
            end else exp_err = 1;
            if (mem_on[t]) begin
                mem_idx[t]++;
                if (m_rlast) mem_on[t] = 0;
            end
            r_pend = 0;
        end else r_pend = m_rvalid;
        prev_stall = out_valid && !out_ready;
        snap = '{tk: out_task, d: out_data, w: int'(out_word_id), st: out_subtype, cq: out_cq_slot, last: out_last};
        @(posedge clk);
        if (rstn) mdl_active = 1;
        @(negedge clk);
    endtask

    task automatic drive_random(input bit en_req);
        int start, t;
        if (!req_pend) begin
            req_valid = en_req && ($urandom % 3 == 0);
            req_araddr = $urandom; req_arlen = 8'($urandom % 4); req_arsize = 3'd3;
            req_task = {$urandom, $urandom}; req_subtype = 3'(1 + $urandom % 2);
            req_mark_last = 1'($urandom % 2); req_cq_slot = 8'($urandom);
        end
        m_arready = ($urandom % 4) != 0;
        out_ready = ($urandom % 4) != 0;
        if (!r_pend) begin
            m_rvalid = 0;
            start = $urandom % N_TAGS;
            for (int k = 0; k < N_TAGS; k++) begin
                t = (start + k) % N_TAGS;
                if (mem_on[t] && !m_rvalid && ($urandom % 3 != 0)) begin
                    m_rvalid = 1; m_rid = TW'(t); m_rdata = {$urandom, $urandom};
                    m_rlast = (mem_idx[t] == mem_len[t]);
                end
            end
        end
        cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 1000; k++) begin
            if (n_busy() == 0 && exp_q.size() == 0 && ar_q.size() == 0 && !r_pend) break;
            drive_random(0);
        end
        chk("drain_done", (n_busy() == 0 && exp_q.size() == 0 && ar_q.size() == 0), 1);
        req_valid = 0; m_rvalid = 0; out_ready = 1; m_arready = 1;
    endtask

    task automatic send_req(input task_t tk, input int st, input bit mark, input int cq, input int len);
        req_valid = 1; req_araddr = $urandom; req_arlen = 8'(len); req_arsize = 3'd3;
        req_task = tk; req_subtype = 3'(st); req_mark_last = mark; req_cq_slot = 8'(cq);
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (!req_pend) break;
        end
        chk("req_accepted", !req_pend, 1);
        req_valid = 0;
    endtask

    task automatic send_beat(input int tag, input logic [63:0] d, input bit last, input int stall);
        m_rvalid = 1; m_rid = TW'(tag); m_rdata = d; m_rlast = last;
        for (int k = 0; k < 40; k++) begin
            out_ready = (k >= stall);
            cycle();
            if (!r_pend) break;
        end
        chk("beat_accepted", !r_pend, 1);
        m_rvalid = 0; out_ready = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 0; req_valid = 0; req_araddr = 0; req_arlen = 0; req_arsize = 3; req_task = '0;
        req_subtype = 0; req_mark_last = 0; req_cq_slot = 0; m_arready = 1;
        m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rlast = 0; out_ready = 1;
        model_reset();
        @(negedge clk);
        cycle(); cycle();
        rstn = 1;
        cycle();

        // single-beat request, fixed data
        send_req({32'd10, 16'd5, 16'd0}, 1, 1, 3, 0);
        cycle();
        send_beat(0, 64'h0000000C_00000008, 1, 0);
        #1;
        chk("tp1_word", out_word_id, 0);
        chk("tp1_data", out_data, 64'h0000000C_00000008);
        chk("tp1_sub", out_subtype, 1);
        chk("tp1_last", out_last, 1);
        cycle();
        chk("tp1_outstanding", outstanding, 0);

        // 4-beat burst, back-to-back
        send_req({$urandom, $urandom}, 2, 1, 9, 3);
        cycle();
        for (int i = 0; i < 4; i++) send_beat(0, {$urandom, $urandom}, i == 3, 0);
        cycle(); cycle();

        // fill all tags, free tag 2, reallocate it
        for (int i = 0; i < N_TAGS; i++) send_req({$urandom, $urandom}, 1, 0, i, 0);
        req_valid = 1; req_arlen = 0; req_task = {$urandom, $urandom};
        #1 chk("full_req_ready", req_ready, 0);
        m_rvalid = 1; m_rid = 3'd2; m_rdata = {$urandom, $urandom}; m_rlast = 1;
        cycle();
        m_rvalid = 0;
        #1 chk("refill_req_ready", req_ready, 1);
        cycle();
        req_valid = 0;
        #1 chk("refill_arid", m_arid, 2);
        cycle();
        drain();

        // interleaved bursts on tags 0 and 1
        send_req({$urandom, $urandom}, 1, 1, 20, 1);
        send_req({$urandom, $urandom}, 2, 1, 21, 1);
        cycle();
        send_beat(0, {$urandom, $urandom}, 0, 0);
        send_beat(1, {$urandom, $urandom}, 0, 0);
        send_beat(0, {$urandom, $urandom}, 1, 0);
        send_beat(1, {$urandom, $urandom}, 1, 0);
        cycle(); cycle();

        // output back-pressure mid-burst
        send_req({$urandom, $urandom}, 2, 1, 30, 3);
        cycle();
        send_beat(0, {$urandom, $urandom}, 0, 0);
        send_beat(0, {$urandom, $urandom}, 0, 5);
        send_beat(0, {$urandom, $urandom}, 0, 0);
        send_beat(0, {$urandom, $urandom}, 1, 0);
        cycle(); cycle();

        // beat for a free tag
        send_beat(6, {$urandom, $urandom}, 1, 0);
        cycle(); cycle();
        chk("unalloc_err", err_unalloc, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) drive_random(1);
        drain();
        cycle();

        // reset in the middle of a burst
        send_req({$urandom, $urandom}, 1, 1, 40, 3);
        cycle();
        send_beat(0, {$urandom, $urandom}, 0, 0);
        m_rvalid = 1; m_rid = 0; m_rdata = {$urandom, $urandom}; m_rlast = 0; out_ready = 0;
        #2 rstn = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unalloc, 0);
        model_reset();
        m_rvalid = 0; out_ready = 1;
        @(negedge clk);
        cycle();
        rstn = 1;
        cycle();
        send_beat(0, {$urandom, $urandom}, 1, 0);
        cycle(); cycle();
        chk("post_rst_err", err_unalloc, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
